fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction fetch sequencer upstream of the halt stage. Holds the PC, issues one
//   instruction-memory read at a time and presents each fetched word to decode with a
//   valid/ready handshake. Detects the HALT opcode, drives the one-cycle halt_signal
//   consumed by the halt stage, and stops fetching permanently until reset.
// PARAMETERS
//   ADDR_W       8      PC / instruction-memory address width
//   INSTR_W      16     instruction word width
//   OPC_W        4      opcode width; opcode = instr[INSTR_W-1 -: OPC_W]
//   HALT_OPCODE  4'hF   opcode value that terminates the program
//   RESET_PC     0      PC value loaded on reset
// PORTS
//   clk          in   1        clock, all state on rising edge
//   rst          in   1        asynchronous, active-low reset (0 = reset)
//   imem_req     out  1        one-cycle read request to instruction memory
//   imem_addr    out  ADDR_W   read address, valid while imem_req=1
//   imem_rdata   in   INSTR_W  read data, sampled when imem_rvalid=1
//   imem_rvalid  in   1        read response; exactly one per request, latency >=1 cycle
//   instr        out  INSTR_W  fetched instruction to decode
//   instr_pc     out  ADDR_W   address the instruction was fetched from
//   instr_valid  out  1        instr/instr_pc valid
//   instr_ready  in   1        decode accepts when instr_valid & instr_ready
//   redirect_en  in   1        load new PC (branch/jump taken)
//   redirect_pc  in   ADDR_W   target PC for redirect
//   halt_signal  out  1        one-cycle pulse to halt stage when HALT fetched
//   halted       out  1        sticky: fetch stopped
// BEHAVIOUR
//   Reset (rst=0, async): pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=0, instr=0,
//     instr_pc=0, instr_valid=0, halt_signal=0, halted=0. Outstanding memory response
//     is not tracked across reset; stray rvalid in FETCH is ignored.
//   States: FETCH, WAIT, HOLD, DRAIN, HALTED.
//   FETCH: imem_req=1, imem_addr=pc for exactly one cycle -> WAIT.
//   WAIT: on imem_rvalid: instr<=rdata, instr_pc<=pc, pc<=pc+1 (wraps mod 2^ADDR_W).
//     opcode!=HALT_OPCODE: instr_valid<=1 -> HOLD.
//     opcode==HALT_OPCODE: instr_valid stays 0, halt_signal<=1 for one cycle,
//       halted<=1 -> HALTED. HALT never reaches decode.
//   HOLD: instr/instr_pc stable while instr_valid=1 & instr_ready=0.
//     instr_ready=1: instr_valid<=0 -> FETCH (next request 1 cycle after accept).
//   HALTED: terminal until reset; imem_req=0, ignores rvalid, ready, redirect.
//   Redirect (all states except HALTED), pc<=redirect_pc, instr_valid<=0:
//     FETCH -> FETCH (pending request cancelled, none issued that cycle).
//     WAIT with no rvalid -> DRAIN (discard in-flight response).
//     WAIT with rvalid same cycle -> response discarded, no halt check -> FETCH.
//     HOLD -> FETCH; if instr_ready also 1 the held instruction counts as accepted.
//     DRAIN -> DRAIN with new pc.
//   DRAIN: wait for imem_rvalid, discard data (no halt check) -> FETCH.
//   Throughput: one instruction per 3 cycles min (req, resp, accept) at 1-cycle latency.
// TESTING
//   1 Reset, imem returns 0x1001,0x2002,0xF000 at 1-cycle latency, ready=1 -> decode
//     sees (pc0,0x1001),(pc1,0x2002); halt_signal pulses once; halted=1; imem_req stays 0.
//   2 Hold 0x1234 with instr_ready=0 for 5 cycles -> instr/instr_pc stable, no new
//     imem_req; ready=1 -> next imem_req after 1 cycle at pc+1.
//   3 redirect_en, redirect_pc=0x40 in WAIT, response after 3 cycles -> response
//     dropped (even if 0xF000), next imem_addr=0x40, no halt_signal.
//   4 PC=0xFF (ADDR_W=8), fetch non-HALT -> next imem_addr=0x00.
//   5 rst=0 asynchronously while in HOLD -> instr_valid, halt_signal drop immediately;
//     after release first imem_addr=RESET_PC.
//   6 In HALTED drive redirect_en, rvalid, ready -> no output change; rst=0 recovers.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: one outstanding imem read, valid/ready hand-off to decode,
// HALT detection with a one-cycle pulse to the halt stage and a sticky stop.
module fetch_unit #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned INSTR_W     = 16,
   parameter int unsigned OPC_W       = 4,
   parameter int unsigned HALT_OPCODE = 'hF,
   parameter int unsigned RESET_PC    = 0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_rvalid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect_en,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               halt_signal,
   output logic               halted
);

   typedef enum logic [2:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN, S_HALTED} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic              run;
   logic [OPC_W-1:0]  opcode;

   assign opcode = imem_rdata[INSTR_W-1 -: OPC_W];

   // The request is decoded from state so a same-cycle redirect can cancel it;
   // run keeps the request low while reset is held and for the first cycle after.
   assign imem_req  = run && (state == S_FETCH) && !redirect_en;
   assign imem_addr = imem_req ? pc : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_FETCH;
         pc          <= ADDR_W'(RESET_PC);
         run         <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         halt_signal <= 1'b0;
         halted      <= 1'b0;
      end else begin
         run         <= 1'b1;
         halt_signal <= 1'b0;
         case (state)
            S_FETCH: begin
               if (redirect_en) pc <= redirect_pc;
               else if (run)    state <= S_WAIT;
            end
            S_WAIT: begin
               if (redirect_en) begin
                  // A response landing with the redirect is stale: drop it, no halt check.
                  pc    <= redirect_pc;
                  state <= imem_rvalid ? S_FETCH : S_DRAIN;
               end else if (imem_rvalid) begin
                  instr    <= imem_rdata;
                  instr_pc <= pc;
                  pc       <= pc + 1'b1;
                  if (opcode == OPC_W'(HALT_OPCODE)) begin
                     halt_signal <= 1'b1;
                     halted      <= 1'b1;
                     state       <= S_HALTED;
                  end else begin
                     instr_valid <= 1'b1;
                     state       <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (redirect_en || instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= S_FETCH;
                  if (redirect_en) pc <= redirect_pc;
               end
            end
            S_DRAIN: begin
               if (redirect_en) pc <= redirect_pc;
               if (imem_rvalid) state <= S_FETCH;
            end
            S_HALTED: ;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule
